video_cfg_ctrl: RTL

Configuration controller for the HDMI video/audio output path.
- Decodes the MCU byte stream (start/strobe/data) into the user settings: scanlines, volume and wide-screen.
- Sequences the HDMI PLL: holds it in reset, waits for lock with a timeout and retries, then re-locks on loss of lock or on a wide-screen change.
- Sits between the MCU SPI receiver and the video output block, in the clk (system) domain.

---
 rtl/video_cfg_pkg.sv | 33 +++
 rtl/pll_lock_seq.sv | 139 +++++++++++++
 rtl/video_cfg_ctrl.sv | 97 +++++++++
 3 files changed

// File: rtl/video_cfg_pkg.sv
// Shared types and constants for the HDMI video/audio configuration controller.
package video_cfg_pkg;

  typedef enum logic [2:0] {
    P_IDLE,
    P_CMD,
    P_IDX,
    P_DATA,
    P_SKIP
  } parser_state_e;

  typedef enum logic [1:0] {
    S_RST,
    S_WAIT,
    S_RUN,
    S_FAIL
  } seq_state_e;

  localparam logic [7:0] IDX_SCANLINES = 8'd0;
  localparam logic [7:0] IDX_VOLUME    = 8'd1;
  localparam logic [7:0] IDX_WIDE      = 8'd2;

  localparam logic [1:0] SCANLINES_RST = 2'd0;
  localparam logic [1:0] VOLUME_RST    = 2'd2;
  localparam logic       WIDE_RST      = 1'b0;

  typedef struct packed {
    logic [1:0] scanlines;
    logic [1:0] volume;
    logic       wide;
  } video_cfg_t;

endpackage

// File: rtl/pll_lock_seq.sv
// HDMI PLL sequencer: reset pulse, lock wait with timeout/retry, lock-loss
// filtering and relock on request.
module pll_lock_seq
  import video_cfg_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES = 32,
  parameter int unsigned LOCK_TIMEOUT   = 65535,
  parameter int unsigned MAX_RETRY      = 3
) (
  input  logic clk,
  input  logic resetn,
  input  logic pll_lock,
  input  logic relock_req,
  output logic hdmi_pll_reset,
  output logic video_ready,
  output logic lock_fail,
  output logic busy
);

  localparam int unsigned CNT_MAX = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 1);

  seq_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d, retry_inc;
  logic               lost_q, lost_d;
  logic               lock_fail_q, lock_fail_d;
  logic               hdmi_pll_reset_q, hdmi_pll_reset_d;
  logic               video_ready_q, video_ready_d;
  logic               busy_q, busy_d;
  logic               sync1_q, lock_s_q;

  // Two-stage synchronizer for the asynchronous PLL lock
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync1_q  <= 1'b0;
      lock_s_q <= 1'b0;
    end else begin
      sync1_q  <= pll_lock;
      lock_s_q <= sync1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q          <= S_RST;
      cnt_q            <= '0;
      retry_q          <= '0;
      lost_q           <= 1'b0;
      lock_fail_q      <= 1'b0;
      hdmi_pll_reset_q <= 1'b1;
      video_ready_q    <= 1'b0;
      busy_q           <= 1'b1;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      retry_q          <= retry_d;
      lost_q           <= lost_d;
      lock_fail_q      <= lock_fail_d;
      hdmi_pll_reset_q <= hdmi_pll_reset_d;
      video_ready_q    <= video_ready_d;
      busy_q           <= busy_d;
    end
  end

  // Outputs are decoded from the next state so they line up with state_q
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    retry_d     = retry_q;
    retry_inc   = retry_q + RETRY_W'(1);
    lost_d      = 1'b0;
    lock_fail_d = lock_fail_q;

    if (relock_req) begin
      state_d = S_RST;
      cnt_d   = '0;
      retry_d = '0;
      if (state_q == S_FAIL) lock_fail_d = 1'b0;
    end else begin
      case (state_q)
        S_RST: begin
          if (cnt_q == CNT_W'(PLL_RST_CYCLES - 1)) begin
            state_d = S_WAIT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_WAIT: begin
          if (lock_s_q) begin
            state_d     = S_RUN;
            cnt_d       = '0;
            retry_d     = '0;
            lock_fail_d = 1'b0;
          end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
            cnt_d   = '0;
            retry_d = retry_inc;
            if (retry_inc == RETRY_W'(MAX_RETRY)) begin
              state_d     = S_FAIL;
              lock_fail_d = 1'b1;
            end else begin
              state_d = S_RST;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_RUN: begin
          // A single low sample is treated as a glitch
          if (!lock_s_q) begin
            if (lost_q) begin
              state_d = S_RST;
              cnt_d   = '0;
              retry_d = '0;
            end else begin
              lost_d = 1'b1;
            end
          end
        end
        S_FAIL: begin
          if (lock_s_q) state_d = S_RUN;
        end
        default: state_d = S_RST;
      endcase
    end

    hdmi_pll_reset_d = (state_d == S_RST);
    video_ready_d    = (state_d == S_RUN);
    busy_d           = (state_d == S_RST) || (state_d == S_WAIT);
  end

  assign hdmi_pll_reset = hdmi_pll_reset_q;
  assign video_ready    = video_ready_q;
  assign lock_fail      = lock_fail_q;
  assign busy           = busy_q;

endmodule

// File: rtl/video_cfg_ctrl.sv
// MCU byte-stream decoder and user-settings register file, driving the HDMI
// PLL sequencer.
module video_cfg_ctrl
  import video_cfg_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES = 32,
  parameter int unsigned LOCK_TIMEOUT   = 65535,
  parameter int unsigned MAX_RETRY      = 3,
  parameter logic [7:0]  CMD_VIDEO      = 8'h03
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       mcu_start,
  input  logic       mcu_strobe,
  input  logic [7:0] mcu_data,
  input  logic       pll_lock,
  output logic       hdmi_pll_reset,
  output logic [1:0] system_scanlines,
  output logic [1:0] system_volume,
  output logic       system_wide_screen,
  output logic       video_ready,
  output logic       lock_fail,
  output logic       busy
);

  localparam video_cfg_t CFG_RST = '{scanlines: SCANLINES_RST, volume: VOLUME_RST, wide: WIDE_RST};

  parser_state_e pstate_q, pstate_d;
  logic [7:0]    idx_q, idx_d;
  video_cfg_t    cfg_q, cfg_d;
  logic          relock_req_c;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pstate_q <= P_IDLE;
      idx_q    <= '0;
      cfg_q    <= CFG_RST;
    end else begin
      pstate_q <= pstate_d;
      idx_q    <= idx_d;
      cfg_q    <= cfg_d;
    end
  end

  // Frame start overrides any strobe in the same cycle
  always_comb begin
    pstate_d     = pstate_q;
    idx_d        = idx_q;
    cfg_d        = cfg_q;
    relock_req_c = 1'b0;

    if (mcu_start) begin
      pstate_d = P_CMD;
    end else if (mcu_strobe) begin
      case (pstate_q)
        P_CMD:  pstate_d = (mcu_data == CMD_VIDEO) ? P_IDX : P_SKIP;
        P_IDX: begin
          idx_d    = mcu_data;
          pstate_d = P_DATA;
        end
        P_DATA: begin
          idx_d = idx_q + 8'd1;
          case (idx_q)
            IDX_SCANLINES: cfg_d.scanlines = mcu_data[1:0];
            IDX_VOLUME:    cfg_d.volume    = mcu_data[1:0];
            IDX_WIDE: begin
              cfg_d.wide   = mcu_data[0];
              relock_req_c = (mcu_data[0] != cfg_q.wide);
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign system_scanlines   = cfg_q.scanlines;
  assign system_volume      = cfg_q.volume;
  assign system_wide_screen = cfg_q.wide;

  pll_lock_seq #(
    .PLL_RST_CYCLES(PLL_RST_CYCLES),
    .LOCK_TIMEOUT  (LOCK_TIMEOUT),
    .MAX_RETRY     (MAX_RETRY)
  ) u_pll_lock_seq (
    .clk           (clk),
    .resetn        (resetn),
    .pll_lock      (pll_lock),
    .relock_req    (relock_req_c),
    .hdmi_pll_reset(hdmi_pll_reset),
    .video_ready   (video_ready),
    .lock_fail     (lock_fail),
    .busy          (busy)
  );

endmodule
